// File: rtl/eth_tx_sched.sv
// Two-source round-robin GMII transmit scheduler: preamble/SFD insertion,
// byte streaming with underrun abort, and minimum inter-packet gap.
// Ports: tx_clk/reset (sync, active-high); src_req/src_vld/src_d/src_eop/
// src_err in, src_rd pop strobe out; gnt one-hot grant; txd/tx_dv/tx_er
// registered GMII outputs; busy; frm_cnt/ufl_cnt saturating counters.
module eth_tx_sched #(
  parameter int PRMBL_LEN = 7,
  parameter int IPG_LEN   = 12
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic [1:0]  src_req,
  input  logic [1:0]  src_vld,
  input  logic [15:0] src_d,
  input  logic [1:0]  src_eop,
  input  logic [1:0]  src_err,
  output logic [1:0]  src_rd,
  output logic [1:0]  gnt,
  output logic [7:0]  txd,
  output logic        tx_dv,
  output logic        tx_er,
  output logic        busy,
  output logic [15:0] frm_cnt,
  output logic [15:0] ufl_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRMBL = 3'd1;
  localparam logic [2:0] S_SFD   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_IPG   = 3'd4;

  localparam logic [5:0] PL = 6'(PRMBL_LEN);
  localparam logic [5:0] IL = 6'(IPG_LEN);

  logic [2:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  pend_q, pend_d;
  logic        rr_q, rr_d;
  logic [7:0]  txd_q, txd_d;
  logic        dv_q, dv_d;
  logic        er_q, er_d;
  logic [15:0] frm_q, frm_d;
  logic [15:0] ufl_q, ufl_d;

  logic [1:0]  req;
  logic        pick;
  logic        g_idx;
  logic [7:0]  g_d;
  logic        g_vld;
  logic        g_eop;
  logic        g_err;

  // Requests arriving while busy are remembered; the granted source's own
  // request is not, so a source holding req through its frame sends once.
  assign req   = pend_q | src_req;
  assign g_idx = gnt_q[1];
  assign g_d   = g_idx ? src_d[15:8] : src_d[7:0];
  assign g_vld = src_vld[g_idx];
  assign g_eop = src_eop[g_idx];
  assign g_err = src_err[g_idx];

  // Popping already in the SFD-output cycle keeps data contiguous with D5.
  assign src_rd = (state_q == S_DATA) ? (gnt_q & src_vld) : 2'b00;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    frm_d   = frm_q;
    ufl_d   = ufl_q;
    pend_d  = pend_q | (src_req & ~gnt_q);
    txd_d   = 8'h00;
    dv_d    = 1'b0;
    er_d    = 1'b0;
    pick    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          pick         = (req == 2'b11) ? rr_q : req[1];
          gnt_d        = pick ? 2'b10 : 2'b01;
          rr_d         = ~pick;
          pend_d[pick] = 1'b0;
          state_d      = S_PRMBL;
          cnt_d        = 6'd1;
          txd_d        = 8'h55;
          dv_d         = 1'b1;
        end
      end
      S_PRMBL: begin
        dv_d = 1'b1;
        // cnt_q = preamble bytes already on the wire
        if (cnt_q >= PL) begin
          txd_d   = 8'hD5;
          state_d = S_DATA;
        end else begin
          txd_d = 8'h55;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q + 6'd1 == PL) state_d = S_SFD;
        end
      end
      S_SFD: begin
        txd_d   = 8'hD5;
        dv_d    = 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        dv_d = 1'b1;
        if (g_vld) begin
          txd_d = g_d;
          er_d  = g_err;
          if (g_eop) begin
            state_d = S_IPG;
            gnt_d   = 2'b00;
            cnt_d   = 6'd0;
            if (frm_q != 16'hFFFF) frm_d = frm_q + 16'd1;
          end
        end else begin
          er_d    = 1'b1;
          state_d = S_IPG;
          gnt_d   = 2'b00;
          cnt_d   = 6'd0;
          if (ufl_q != 16'hFFFF) ufl_d = ufl_q + 16'd1;
        end
      end
      S_IPG: begin
        // Leaving on the IL-th low cycle lets IDLE grant on the next edge,
        // giving exactly IL low cycles before the next preamble.
        if (cnt_q == IL - 6'd1) state_d = S_IDLE;
        else cnt_d = cnt_q + 6'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      gnt_q   <= 2'b00;
      pend_q  <= 2'b00;
      rr_q    <= 1'b0;
      txd_q   <= 8'h00;
      dv_q    <= 1'b0;
      er_q    <= 1'b0;
      frm_q   <= 16'd0;
      ufl_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      txd_q   <= txd_d;
      dv_q    <= dv_d;
      er_q    <= er_d;
      frm_q   <= frm_d;
      ufl_q   <= ufl_d;
    end
  end

  assign gnt     = gnt_q;
  assign txd     = txd_q;
  assign tx_dv   = dv_q;
  assign tx_er   = er_q;
  assign busy    = (state_q != S_IDLE);
  assign frm_cnt = frm_q;
  assign ufl_cnt = ufl_q;

endmodule
